// File: rtl/hybridsub8_seq.sv
// Multi-cycle 8-bit subtractor: D = X - Y - B0 over three stages.
// Stages: 2-bit ripple, 4-bit borrow lookahead, 2-bit ripple; D and B8 update only at completion.
module hybridsub8_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic       B0,
   output logic [7:0] D,
   output logic       B8,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO2  = 2'd1,
      MID4 = 2'd2,
      HI2  = 2'd3
   } state_t;

   state_t     state_q;
   logic [7:0] x_q;
   logic [7:0] y_q;
   logic       b0_q;
   logic [5:0] part_q;
   logic       brw_q;
   logic [7:0] d_q;
   logic       b8_q;
   logic       busy_q;
   logic       done_q;

   logic [2:0] lo_d;
   logic [4:0] mid_d;
   logic [2:0] hi_d;

   // Returns {borrow_out, diff[1:0]}.
   function automatic logic [2:0] ripple2(input logic [1:0] xv,
                                          input logic [1:0] yv,
                                          input logic       bin);
      logic       b;
      logic [1:0] dv;
      b  = bin;
      dv = 2'b00;
      for (int i = 0; i < 2; i++) begin
         dv[i] = xv[i] ^ yv[i] ^ b;
         b     = (~xv[i] & yv[i]) | (~(xv[i] ^ yv[i]) & b);
      end
      return {b, dv};
   endfunction

   // Returns {borrow_out, diff[3:0]}; every internal borrow is a flat sum of products.
   function automatic logic [4:0] lookahead4(input logic [3:0] xv,
                                             input logic [3:0] yv,
                                             input logic       bin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = ~xv & yv;
      p    = ~(xv ^ yv);
      c[0] = bin;
      c[1] = g[0] | (p[0] & bin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & bin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (&p & bin);
      return {c[4], xv ^ yv ^ c[3:0]};
   endfunction

   always_comb begin
      lo_d  = ripple2(x_q[1:0], y_q[1:0], b0_q);
      mid_d = lookahead4(x_q[5:2], y_q[5:2], brw_q);
      hi_d  = ripple2(x_q[7:6], y_q[7:6], brw_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= 8'h00;
         y_q     <= 8'h00;
         b0_q    <= 1'b0;
         part_q  <= 6'h00;
         brw_q   <= 1'b0;
         d_q     <= 8'h00;
         b8_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q     <= X;
                  y_q     <= Y;
                  b0_q    <= B0;
                  part_q  <= 6'h00;
                  brw_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= LO2;
               end
            end
            LO2: begin
               part_q[1:0] <= lo_d[1:0];
               brw_q       <= lo_d[2];
               state_q     <= MID4;
            end
            MID4: begin
               part_q[5:2] <= mid_d[3:0];
               brw_q       <= mid_d[4];
               state_q     <= HI2;
            end
            HI2: begin
               d_q     <= {hi_d[1:0], part_q};
               b8_q    <= hi_d[2];
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign D    = d_q;
   assign B8   = b8_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_hybridsub8_seq.sv
// Directed bench for hybridsub8_seq: vector table plus hand-written
// sequences for mid-operation start, back-to-back starts and reset abort.
module tb_hybridsub8_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] X;
   logic [7:0] Y;
   logic       B0;
   logic [7:0] D;
   logic       B8;
   logic       busy;
   logic       done;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       b0;
      logic [7:0] d;
      logic       b8;
   } vec_t;

   vec_t vecs[10];

   logic [7:0] exp_d;
   logic       exp_b8;

   always #5 clk = ~clk;

   hybridsub8_seq dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .X    (X),
      .Y    (Y),
      .B0   (B0),
      .D    (D),
      .B8   (B8),
      .busy (busy),
      .done (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tot_cnt++;
      if (act === want) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", name, act, want);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full operation, with the operand inputs scrambled while busy.
   task automatic run_op(input vec_t v);
      start = 1'b1; X = v.x; Y = v.y; B0 = v.b0;
      tick();
      chk("accept_busy", busy, 1'b1);
      chk("accept_done", done, 1'b0);
      chk("accept_hold_d", D, exp_d);
      start = 1'b0; X = ~v.x; Y = ~v.y; B0 = ~v.b0;
      tick();
      chk("n1_busy", busy, 1'b1);
      chk("n1_hold_d", D, exp_d);
      tick();
      chk("n2_busy", busy, 1'b1);
      chk("n2_hold_d", D, exp_d);
      chk("n2_hold_b8", B8, exp_b8);
      chk("n2_done", done, 1'b0);
      tick();
      exp_d  = v.d;
      exp_b8 = v.b8;
      chk("n3_d", D, exp_d);
      chk("n3_b8", B8, exp_b8);
      chk("n3_done", done, 1'b1);
      chk("n3_busy", busy, 1'b0);
      tick();
      chk("n4_done", done, 1'b0);
      chk("n4_busy", busy, 1'b0);
      chk("n4_d", D, exp_d);
   endtask

   initial begin
      vecs[0] = '{x: 8'hFF, y: 8'hFE, b0: 1'b0, d: 8'h01, b8: 1'b0};
      vecs[1] = '{x: 8'hAA, y: 8'h55, b0: 1'b0, d: 8'h55, b8: 1'b0};
      vecs[2] = '{x: 8'h08, y: 8'h81, b0: 1'b1, d: 8'h86, b8: 1'b1};
      vecs[3] = '{x: 8'h00, y: 8'h00, b0: 1'b1, d: 8'hFF, b8: 1'b1};
      vecs[4] = '{x: 8'h01, y: 8'h00, b0: 1'b0, d: 8'h01, b8: 1'b0};
      vecs[5] = '{x: 8'h00, y: 8'hFF, b0: 1'b1, d: 8'h00, b8: 1'b1};
      vecs[6] = '{x: 8'hFF, y: 8'h00, b0: 1'b1, d: 8'hFE, b8: 1'b0};
      vecs[7] = '{x: 8'h80, y: 8'h7F, b0: 1'b0, d: 8'h01, b8: 1'b0};
      vecs[8] = '{x: 8'h3C, y: 8'h3C, b0: 1'b0, d: 8'h00, b8: 1'b0};
      vecs[9] = '{x: 8'h3C, y: 8'h3C, b0: 1'b1, d: 8'hFF, b8: 1'b1};

      rst = 1'b1; start = 1'b1; X = 8'h12; Y = 8'h34; B0 = 1'b0;
      exp_d = 8'h00; exp_b8 = 1'b0;
      tick();
      chk("rst_d", D, 8'h00);
      chk("rst_b8", B8, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      start = 1'b0;
      rst   = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_busy", busy, 1'b0);
         chk("idle_done", done, 1'b0);
         chk("idle_d", D, 8'h00);
      end

      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      // Start re-asserted with new operands during the operation is ignored.
      start = 1'b1; X = 8'hF0; Y = 8'h88; B0 = 1'b0;
      tick();
      X = 8'h00; Y = 8'hFF;
      tick();
      chk("mid_n1_busy", busy, 1'b1);
      tick();
      chk("mid_n2_busy", busy, 1'b1);
      tick();
      chk("mid_n3_d", D, 8'h68);
      chk("mid_n3_b8", B8, 1'b0);
      chk("mid_n3_done", done, 1'b1);
      start = 1'b0;
      tick();
      chk("mid_n4_busy", busy, 1'b0);
      chk("mid_n4_done", done, 1'b0);
      chk("mid_n4_d", D, 8'h68);

      // Start held high: second operation accepted in the done cycle.
      start = 1'b1; X = 8'h60; Y = 8'h7F; B0 = 1'b0;
      tick();
      X = 8'hFF; Y = 8'h01;
      tick();
      tick();
      tick();
      chk("b2b_n3_d", D, 8'hE1);
      chk("b2b_n3_b8", B8, 1'b1);
      chk("b2b_n3_done", done, 1'b1);
      tick();
      chk("b2b_n4_done", done, 1'b0);
      chk("b2b_n4_busy", busy, 1'b1);
      chk("b2b_n4_d", D, 8'hE1);
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("b2b_n7_d", D, 8'hFE);
      chk("b2b_n7_b8", B8, 1'b0);
      chk("b2b_n7_done", done, 1'b1);
      tick();
      chk("b2b_n8_done", done, 1'b0);
      chk("b2b_n8_busy", busy, 1'b0);

      // Reset between N+1 and N+2 aborts the operation immediately.
      start = 1'b1; X = 8'hFF; Y = 8'h00; B0 = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_d", D, 8'h00);
      chk("arst_b8", B8, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_done", done, 1'b0);
         chk("post_rst_busy", busy, 1'b0);
      end
      exp_d  = 8'h00;
      exp_b8 = 1'b0;
      run_op(vecs[2]);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
